// File: rtl/draw_port_arbiter_pkg.sv
// draw_port_arbiter_pkg: shared widths, colours, arbiter state encoding and round-robin helper
package draw_port_arbiter_pkg;
   localparam int XW_DEF = 10;
   localparam int YW_DEF = 10;
   localparam int CW_DEF = 3;
   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, RELEASE = 2'd2} arb_state_t;
   function automatic int rr_slot(int last, int k, int n);
      return (last + k) % n;
   endfunction
endpackage

// File: rtl/draw_port_arbiter_if.sv
// draw_port_arbiter_if: draw engines (master) to framebuffer-port arbiter (slave) bundle
interface draw_port_arbiter_if import draw_port_arbiter_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int XW = XW_DEF,
   parameter int YW = YW_DEF,
   parameter int CW = CW_DEF
);
   logic [N_REQ-1:0] req, done, wren_in, gnt;
   logic [N_REQ*XW-1:0] x_in;
   logic [N_REQ*YW-1:0] y_in;
   logic [N_REQ*CW-1:0] color_in;
   logic vga_wren, busy, timeout;
   logic [XW-1:0] vga_x;
   logic [YW-1:0] vga_y;
   logic [CW-1:0] vga_color;
   modport master(output req, done, wren_in, x_in, y_in, color_in,
                  input gnt, vga_wren, vga_x, vga_y, vga_color, busy, timeout);
   modport slave(input req, done, wren_in, x_in, y_in, color_in,
                 output gnt, vga_wren, vga_x, vga_y, vga_color, busy, timeout);
endinterface

// File: rtl/draw_port_arbiter_rr_picker.sv
// rr_picker: first requester after last owner, as one-hot and index
module rr_picker import draw_port_arbiter_pkg::*; #(
   parameter int N = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  pick,
   output logic [IW-1:0] idx
);
   // scan from farthest to nearest so the nearest set request overwrites the rest
   always_comb begin
      pick = '0;
      idx = '0;
      for (int k = N; k >= 1; k--) begin
         if (req[rr_slot(int'(last), k, N)]) begin
            pick = '0;
            pick[rr_slot(int'(last), k, N)] = 1'b1;
            idx = IW'(rr_slot(int'(last), k, N));
         end
      end
   end
endmodule

// File: rtl/draw_port_arbiter.sv
// draw_port_arbiter: round-robin owner of the VGA write port; DRAW_ARB_TIMEOUT_EN adds forced release
module draw_port_arbiter import draw_port_arbiter_pkg::*; #(
   parameter int N_REQ = 4,
   parameter int XW = XW_DEF,
   parameter int YW = YW_DEF,
   parameter int CW = CW_DEF,
   parameter int TIMEOUT = 4096
) (
   input logic clk,
   input logic resetn,
   draw_port_arbiter_if.slave bus
);
   localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
   arb_state_t state;
   logic [IW-1:0] owner, pick_idx;
   logic [N_REQ-1:0] pick;
   logic fin, strobe;
   assign fin = bus.done[owner] | ~bus.req[owner];
   assign strobe = bus.wren_in[owner];
   rr_picker #(.N(N_REQ), .IW(IW)) u_picker (.req(bus.req), .last(owner), .pick(pick), .idx(pick_idx));
`ifdef DRAW_ARB_TIMEOUT_EN
   logic [11:0] hold;
   logic expire;
   assign expire = hold == 12'(TIMEOUT - 1);
`else
   assign bus.timeout = 1'b0;
`endif
   // grant FSM; owner doubles as last_owner for the next round-robin scan
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         owner <= IW'(N_REQ - 1);
         bus.gnt <= '0;
         bus.busy <= 1'b0;
         bus.vga_wren <= 1'b0;
         bus.vga_x <= '0;
         bus.vga_y <= '0;
         bus.vga_color <= CW'(BLACK);
`ifdef DRAW_ARB_TIMEOUT_EN
         bus.timeout <= 1'b0;
         hold <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (|bus.req) begin
               bus.gnt <= pick;
               owner <= pick_idx;
               bus.busy <= 1'b1;
               state <= OWN;
`ifdef DRAW_ARB_TIMEOUT_EN
               hold <= '0;
`endif
            end
            OWN: begin
               bus.vga_wren <= strobe;
               if (strobe) begin
                  bus.vga_x <= bus.x_in[int'(owner)*XW +: XW];
                  bus.vga_y <= bus.y_in[int'(owner)*YW +: YW];
                  bus.vga_color <= bus.color_in[int'(owner)*CW +: CW];
               end
`ifdef DRAW_ARB_TIMEOUT_EN
               hold <= hold + 12'd1;
               if (expire) begin
                  bus.vga_wren <= 1'b0;
                  bus.vga_x <= bus.vga_x;
                  bus.vga_y <= bus.vga_y;
                  bus.vga_color <= bus.vga_color;
                  bus.timeout <= 1'b1;
                  bus.gnt <= '0;
                  bus.busy <= 1'b0;
                  state <= RELEASE;
               end else
`endif
               if (fin) begin
                  bus.gnt <= '0;
                  bus.busy <= 1'b0;
                  state <= RELEASE;
               end
            end
            RELEASE: begin
               bus.vga_wren <= 1'b0;
`ifdef DRAW_ARB_TIMEOUT_EN
               bus.timeout <= 1'b0;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_draw_port_arbiter.sv
// tb_draw_port_arbiter: directed vector table plus round-robin, regrant and hold sequences
module tb_draw_port_arbiter;
   logic clk = 1'b0, resetn = 1'b0;
   int n_cmp = 0, n_err = 0;
   always #5 clk = ~clk;

   draw_port_arbiter_if #(.N_REQ(4), .XW(10), .YW(10), .CW(3)) bus();
   draw_port_arbiter #(.N_REQ(4), .XW(10), .YW(10), .CW(3), .TIMEOUT(16)) dut (
      .clk(clk), .resetn(resetn), .bus(bus));

   typedef struct {
      logic [3:0] req, done, wren;
      logic [39:0] x, y;
      logic [11:0] c;
      logic [3:0] eg;
      logic ew;
      logic [9:0] ex, ey;
      logic [2:0] ec;
      logic eb;
   } vec_t;
   vec_t tv[17];

   function automatic vec_t mk(logic [3:0] req, done, wren, logic [39:0] x, y, logic [11:0] c,
                               logic [3:0] eg, logic ew, logic [9:0] ex, ey, logic [2:0] ec, logic eb);
      vec_t v;
      v.req = req; v.done = done; v.wren = wren; v.x = x; v.y = y; v.c = c;
      v.eg = eg; v.ew = ew; v.ex = ex; v.ey = ey; v.ec = ec; v.eb = eb;
      return v;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req = '0; bus.done = '0; bus.wren_in = '0;
      bus.x_in = '0; bus.y_in = '0; bus.color_in = '0;
   endtask

   initial begin
      localparam logic [39:0] Z40 = '0;
      localparam logic [11:0] Z12 = '0;
      localparam logic [39:0] XA = {10'd0, 10'd0, 10'd9, 10'd5};
      localparam logic [39:0] YA = {10'd0, 10'd0, 10'd9, 10'd7};
      localparam logic [11:0] CA = {3'd0, 3'd0, 3'd1, 3'd7};
      int order[$];
      logic [9:0] expx[$];
      int grants, sent, own, pix, wait_n, bad, to_seen;
      tv[0]  = mk(4'b0101, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0001, 1'b0, 10'd0, 10'd0, 3'd0, 1'b1);
      tv[1]  = mk(4'b0101, 4'b0000, 4'b0011, XA, YA, CA, 4'b0001, 1'b1, 10'd5, 10'd7, 3'd7, 1'b1);
      tv[2]  = mk(4'b0101, 4'b0000, 4'b0010, XA, YA, CA, 4'b0001, 1'b0, 10'd5, 10'd7, 3'd7, 1'b1);
      tv[3]  = mk(4'b0101, 4'b0010, 4'b0000, Z40, Z40, Z12, 4'b0001, 1'b0, 10'd5, 10'd7, 3'd7, 1'b1);
      tv[4]  = mk(4'b0101, 4'b0001, 4'b0001, {30'd0, 10'd6}, {30'd0, 10'd8}, {9'd0, 3'd3},
                  4'b0000, 1'b1, 10'd6, 10'd8, 3'd3, 1'b0);
      tv[5]  = mk(4'b0100, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd6, 10'd8, 3'd3, 1'b0);
      tv[6]  = mk(4'b0100, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0100, 1'b0, 10'd6, 10'd8, 3'd3, 1'b1);
      tv[7]  = mk(4'b0100, 4'b0000, 4'b0101, {10'd0, 10'd100, 10'd0, 10'd1}, {10'd0, 10'd200, 10'd0, 10'd1},
                  {3'd0, 3'd5, 3'd0, 3'd1}, 4'b0100, 1'b1, 10'd100, 10'd200, 3'd5, 1'b1);
      tv[8]  = mk(4'b0000, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[9]  = mk(4'b0010, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[10] = mk(4'b0010, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0010, 1'b0, 10'd100, 10'd200, 3'd5, 1'b1);
      tv[11] = mk(4'b0011, 4'b0010, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[12] = mk(4'b0011, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[13] = mk(4'b0011, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0001, 1'b0, 10'd100, 10'd200, 3'd5, 1'b1);
      tv[14] = mk(4'b0011, 4'b0001, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[15] = mk(4'b0010, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0000, 1'b0, 10'd100, 10'd200, 3'd5, 1'b0);
      tv[16] = mk(4'b0010, 4'b0000, 4'b0000, Z40, Z40, Z12, 4'b0010, 1'b0, 10'd100, 10'd200, 3'd5, 1'b1);

      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_gnt", bus.gnt, 0);
      chk("reset_wren", bus.vga_wren, 0);
      chk("reset_xyc", {bus.vga_x, bus.vga_y, bus.vga_color}, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_timeout", bus.timeout, 0);
      @(negedge clk) resetn = 1'b1;

      foreach (tv[i]) begin
         @(negedge clk);
         bus.req = tv[i].req; bus.done = tv[i].done; bus.wren_in = tv[i].wren;
         bus.x_in = tv[i].x; bus.y_in = tv[i].y; bus.color_in = tv[i].c;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_gnt", i), bus.gnt, tv[i].eg);
         chk($sformatf("v%0d_wren", i), bus.vga_wren, tv[i].ew);
         chk($sformatf("v%0d_x", i), bus.vga_x, tv[i].ex);
         chk($sformatf("v%0d_y", i), bus.vga_y, tv[i].ey);
         chk($sformatf("v%0d_color", i), bus.vga_color, tv[i].ec);
         chk($sformatf("v%0d_busy", i), bus.busy, tv[i].eb);
      end

      // engine 1 holds the port here; reset mid-grant must abort it
      @(negedge clk) begin idle_inputs(); resetn = 1'b0; end
      @(posedge clk);
      #1;
      chk("midreset_gnt", bus.gnt, 0);
      chk("midreset_busy", bus.busy, 0);
      @(negedge clk) resetn = 1'b1;

      // all engines request; each draws three pixels, done on the third
      bus.req = 4'hF;
      grants = 0; sent = 0; own = -1; pix = 0;
      for (int cyc = 0; cyc < 50; cyc++) begin
         @(negedge clk);
         if (bus.vga_wren) begin
            pix++;
            if (expx.size() == 0) chk("rr_unexpected_pixel", bus.vga_x, 10'h3ff);
            else chk("rr_pixel_x", bus.vga_x, expx.pop_front());
         end
         if (bus.gnt != 0) chk("rr_onehot", $onehot(bus.gnt), 1);
         bus.wren_in = '0; bus.done = '0; bus.x_in = '0;
         if (grants == 5 && sent == 3) bus.req = '0;
         if (bus.gnt != 0 && own < 0) begin
            for (int k = 0; k < 4; k++) if (bus.gnt[k]) own = k;
            order.push_back(own);
            grants++;
            sent = 0;
         end
         if (own >= 0) begin
            bus.wren_in[own] = 1'b1;
            bus.x_in[own*10 +: 10] = 10'(own*16 + sent);
            expx.push_back(10'(own*16 + sent));
            sent++;
            if (sent == 3) begin
               bus.done[own] = 1'b1;
               own = -1;
            end
         end
      end
      chk("rr_grants", grants, 5);
      chk("rr_pixels", pix, 15);
      for (int k = 0; k < 5; k++) chk($sformatf("rr_order%0d", k), k < order.size() ? order[k] : -1, k % 4);

      // single requester: done at grant, regranted exactly three clocks later
      idle_inputs();
      bus.req = 4'b0001;
      wait_n = 0;
      do begin @(negedge clk); wait_n++; end while (bus.gnt != 4'b0001 && wait_n < 10);
      chk("single_first_gnt", bus.gnt, 4'b0001);
      bus.done = 4'b0001;
      @(negedge clk) bus.done = '0;
      chk("single_gap1", bus.gnt, 0);
      @(negedge clk);
      chk("single_gap2", bus.gnt, 0);
      @(negedge clk);
      chk("single_regrant", bus.gnt, 4'b0001);

      // owner streams pixels and never sends done
      bus.wren_in = 4'b0001;
      bus.x_in = 40'd33;
`ifdef DRAW_ARB_TIMEOUT_EN
      to_seen = 0;
      for (int cyc = 1; cyc <= 40 && to_seen == 0; cyc++) begin
         @(negedge clk);
         if (bus.timeout) begin
            to_seen = cyc;
            chk("to_gnt", bus.gnt, 0);
            chk("to_busy", bus.busy, 0);
            chk("to_wren_suppressed", bus.vga_wren, 0);
         end
      end
      chk("to_cycle", to_seen, 16);
      @(negedge clk);
      chk("to_pulse_width", bus.timeout, 0);
`else
      bad = 0; to_seen = 0;
      for (int cyc = 0; cyc < 120; cyc++) begin
         @(negedge clk);
         if (bus.gnt != 4'b0001) bad++;
         if (bus.timeout) to_seen++;
      end
      chk("hold_gnt_lost_cycles", bad, 0);
      chk("hold_timeout_pulses", to_seen, 0);
      chk("hold_wren", bus.vga_wren, 1);
      chk("hold_x", bus.vga_x, 33);
`endif
      idle_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
